if_fetch_bpred: RTL

- Instruction-fetch stage with an integrated branch target buffer (BTB) and 2-bit saturating-counter branch predictor.
- Owns the 12-bit fetch PC and drives the instruction-memory address.
- Produces the pc and bpr values that the IF/ID register latches.
- Takes resolved-branch updates and misprediction redirects back from EX.

---
 rtl/if_fetch_bpred_pkg.sv | 33 +++
 rtl/if_fetch_bpred_bp_table.sv | 63 ++++++
 rtl/if_fetch_bpred.sv | 85 ++++++++
 3 files changed

// File: rtl/if_fetch_bpred_pkg.sv
// Shared types for the fetch stage and its branch predictor.
// Counter encodings, PC width and the saturating counter update.
package if_fetch_bpred_pkg;

   localparam int PC_W = 12;
   localparam logic [PC_W-1:0] RESET_PC_DEF = 12'h000;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic            taken;
      logic [PC_W-1:0] target;
   } upd_t;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken) begin
         if (c != ST) r = ctr_t'(c + 2'd1);
      end else begin
         if (c != SNT) r = ctr_t'(c - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/if_fetch_bpred_bp_table.sv
// Direct-mapped BTB with a 2-bit counter per entry.
// Lookup is combinational; update is written on the clock edge.
module bp_table
   import if_fetch_bpred_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc,
   output logic            hit,
   output ctr_t            ctr,
   output logic [PC_W-1:0] target,
   input  upd_t            upd
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int TW  = PC_W - IDX - 2;

   logic            valid_q [ENTRIES];
   logic [TW-1:0]   tag_q   [ENTRIES];
   logic [PC_W-1:0] tgt_q   [ENTRIES];
   ctr_t            ctr_q   [ENTRIES];

   logic [IDX-1:0] idx;
   logic [IDX-1:0] uidx;
   logic [TW-1:0]  utag;
   logic           uhit;
   logic           unused;

   assign idx    = pc[IDX+1:2];
   assign hit    = valid_q[idx] && (tag_q[idx] == pc[PC_W-1:IDX+2]);
   assign ctr    = ctr_q[idx];
   assign target = tgt_q[idx];

   assign uidx   = upd.pc[IDX+1:2];
   assign utag   = upd.pc[PC_W-1:IDX+2];
   assign uhit   = valid_q[uidx] && (tag_q[uidx] == utag);
   assign unused = ^{pc[1:0], upd.pc[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= WNT;
         end
      end else if (upd.valid) begin
         if (uhit) begin
            ctr_q[uidx] <= ctr_next(ctr_q[uidx], upd.taken);
            if (upd.taken) tgt_q[uidx] <= upd.target;
         end else if (upd.taken) begin
            // Miss on a taken branch replaces whatever lived in this slot
            valid_q[uidx] <= 1'b1;
            tag_q[uidx]   <= utag;
            tgt_q[uidx]   <= upd.target;
            ctr_q[uidx]   <= WT;
         end
      end
   end

endmodule

// File: rtl/if_fetch_bpred.sv
// Fetch stage: PC register, next-PC selection and BTB prediction.
// Define BP_PERF_EN to add update/mispredict event counters.
module if_fetch_bpred
   import if_fetch_bpred_pkg::*;
#(
   parameter int              ENTRIES  = 16,
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            latchn,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   input  logic            upd_valid_i,
   input  logic [PC_W-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [PC_W-1:0] upd_target_i,
`ifdef BP_PERF_EN
   output logic [15:0]     perf_upd_o,
   output logic [15:0]     perf_misp_o,
`endif
   output logic [PC_W-1:0] imem_addr_o,
   output logic [PC_W-1:0] pc_o,
   output logic            bpr_o,
   output logic [PC_W-1:0] pred_target_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_nxt;
   logic            hit;
   ctr_t            ctr;
   logic [PC_W-1:0] target;
   upd_t            upd;
   logic            unused;

   assign upd = '{
      valid:  upd_valid_i,
      pc:     upd_pc_i,
      taken:  upd_taken_i,
      target: upd_target_i
   };

   bp_table #(.ENTRIES(ENTRIES)) u_table (
      .clk    (CLK),
      .rst    (RST),
      .pc     (pc_q),
      .hit    (hit),
      .ctr    (ctr),
      .target (target),
      .upd    (upd)
   );

   assign bpr_o         = hit & ctr[1];
   assign pred_target_o = bpr_o ? target : '0;
   assign pc_o          = pc_q;
   assign imem_addr_o   = pc_q;
   assign unused        = ^redirect_pc_i[1:0];

   always_comb begin
      pc_nxt = pc_q + 12'd4;
      if (redirect_i)  pc_nxt = {redirect_pc_i[PC_W-1:2], 2'b00};
      else if (latchn) pc_nxt = pc_q;
      else if (bpr_o)  pc_nxt = pred_target_o;
   end

   always_ff @(posedge CLK) begin
      if (RST) pc_q <= RESET_PC;
      else     pc_q <= pc_nxt;
   end

`ifdef BP_PERF_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_upd_o  <= '0;
         perf_misp_o <= '0;
      end else begin
         if (upd_valid_i && (perf_upd_o != 16'hFFFF))
            perf_upd_o <= perf_upd_o + 16'd1;
         if (redirect_i && (perf_misp_o != 16'hFFFF))
            perf_misp_o <= perf_misp_o + 16'd1;
      end
   end
`endif

endmodule
